// File: rtl/if_controller_pkg.sv
// Shared types for the feature-buffer streaming controller: FSM state
// encoding and the drain-length helper derived from the array size.
package if_controller_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } if_state_e;

    // Array skew plus buffer read latency, in cycles per array row.
    localparam int DRAIN_CYC_PER_ROW = 2;

    function automatic int drain_cyc(input int rows);
        return DRAIN_CYC_PER_ROW * rows;
    endfunction

endpackage

// File: rtl/if_controller.sv
// Streams if_len feature vectors from the buffer into the systolic array,
// then waits for the array to drain. Optional backpressure: IF_CTRL_STALL_EN.
module if_controller
    import if_controller_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_if,
    input  logic [ADDR_W-1:0] if_base,
    input  logic [ADDR_W-1:0] if_len,
    output logic              if_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              if_valid,
    output logic              acc_clr,
    output logic              if_done
`ifdef IF_CTRL_STALL_EN
    ,
    input  logic              stall
`endif
);

    localparam int DRAIN_CYC = drain_cyc(ROWS);
    localparam int DW        = $clog2(DRAIN_CYC + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

    if_state_e         state_q, state_d;
    logic [ADDR_W-1:0] base_q, len_q, count_q;
    logic [DW-1:0]     drain_q;
    logic              hold;

`ifdef IF_CTRL_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    // NOTE: every output of this block gets a default before the case so
    // that no path leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d  = state_q;
        if_ready = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        if_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if_ready = 1'b1;
                if (start_if)
                    state_d = (if_len == '0) ? DONE : STREAM;
            end
            STREAM: begin
                if (!hold) begin
                    rd_en   = 1'b1;
                    rd_addr = base_q + count_q;
                    if (count_q == len_q - ADDR_W'(1))
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!hold && drain_q == DRAIN_LAST)
                    state_d = DONE;
            end
            DONE: begin
                if_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            drain_q  <= '0;
            base_q   <= '0;
            len_q    <= '0;
            if_valid <= 1'b0;
            acc_clr  <= 1'b0;
        end else begin
            state_q  <= state_d;
            if_valid <= rd_en;
            acc_clr  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_if) begin
                        base_q  <= if_base;
                        len_q   <= if_len;
                        count_q <= '0;
                        drain_q <= '0;
                        acc_clr <= (if_len != '0);
                    end
                end
                STREAM: if (rd_en) count_q <= count_q + ADDR_W'(1);
                DRAIN:  if (!hold) drain_q <= drain_q + DW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: doc/if_controller.md
IF_CONTROLLER -- requirements
Module: if_controller

Interface
REQ-001 SHALL have parameter ROWS, default 4: systolic array dimension.
REQ-002 SHALL have parameter ADDR_W, default 8: feature-buffer address width.
REQ-003 SHALL have ports as listed in REQ-004 to REQ-015.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-low (rst==0 resets on a clock edge).
REQ-006 start_if  input  1  start pulse from weight controller; also the weight-bank switch point.
REQ-007 if_base  input  ADDR_W  first feature-buffer address; sampled on accepted start_if.
REQ-008 if_len  input  ADDR_W  number of feature vectors to stream; sampled on accepted start_if.
REQ-009 if_ready  output  1  high = idle, can accept start_if.
REQ-010 rd_en  output  1  feature-buffer read enable.
REQ-011 rd_addr  output  ADDR_W  feature-buffer read address.
REQ-012 if_valid  output  1  feature vector on buffer data bus valid into array (rd_en delayed 1 cycle).
REQ-013 acc_clr  output  1  one-cycle pulse clearing array accumulators at stream start.
REQ-014 if_done  output  1  one-cycle pulse when array fully drained.
REQ-015 stall  input  1  array backpressure; present only with IF_CTRL_STALL_EN.

Function
REQ-016 SHALL implement FSM states IDLE, STREAM, DRAIN, DONE.
REQ-017 SHALL drive if_ready=1 only in IDLE, combinationally from state.
REQ-018 IDLE: start_if=1 SHALL latch if_base/if_len into internal registers, assert acc_clr next cycle, and go to STREAM; if if_len==0, go to DONE instead and assert no acc_clr.
REQ-019 start_if outside IDLE SHALL be ignored, with no effect on state or counters.
REQ-020 STREAM: rd_en=1 each cycle; rd_addr = base + count; count increments per issued read.
REQ-021 Read issued with count==len-1 SHALL be the last; next state DRAIN.
REQ-022 rd_addr SHALL wrap modulo 2^ADDR_W; no overflow error.
REQ-023 if_valid SHALL equal rd_en registered by one cycle; buffer read latency is fixed at 1.
REQ-024 DRAIN SHALL last exactly 2*ROWS cycles, covering array skew plus read latency, then go to DONE.
REQ-025 DONE SHALL last one cycle with if_done=1, then go to IDLE.
REQ-026 Timing: start_if at cycle t SHALL give acc_clr and first rd_en at t+1, and if_done at t+1+len+2*ROWS.
REQ-027 if_ready at the end of a run SHALL rise in the cycle after if_done; start_if in that cycle SHALL be accepted.
REQ-028 Undefined state encodings SHALL return to IDLE with all outputs 0.

Reset
REQ-029 rst==0 at a clock edge SHALL force IDLE and zero count, rd_addr, rd_en, if_valid, acc_clr and if_done; if_ready SHALL then be 1.
REQ-030 Reset mid-STREAM or mid-DRAIN SHALL abort with no if_done pulse; latched base/len values SHALL be don't-care.

Configuration
REQ-031 Macro IF_CTRL_STALL_EN, when defined, SHALL add the stall port.
REQ-032 With the macro: in STREAM, stall=1 SHALL force rd_en=0 and freeze count.
REQ-033 With the macro: in DRAIN, stall=1 SHALL freeze the drain counter.
REQ-034 With the macro: stall SHALL be ignored in IDLE and DONE.
REQ-035 Without the macro, there SHALL be no stall port and streaming SHALL be uninterrupted.

Structure
REQ-036 Shared package SHALL hold the FSM state enum (2-bit) and localparam DRAIN_CYC = 2*ROWS helper.
REQ-037 Single module, no sub-modules; the drain counter SHALL be sized $clog2(2*ROWS+1).

Verification
REQ-038 ROWS=4, base=8'h10, len=3, start_if at t0: rd_addr 10,11,12 at t0+1..t0+3; if_valid t0+2..t0+4; if_done at t0+12; if_ready at t0+13.
REQ-039 len=0: if_done at t0+1; rd_en and acc_clr stay 0.
REQ-040 base=8'hFE, len=4: rd_addr sequence FE,FF,00,01.
REQ-041 start_if repeated during STREAM: ignored, sequence unchanged; start_if in the cycle if_ready rises: new run starts next cycle.
REQ-042 rst low at t0+2 of a len=5 run: all outputs 0 and if_ready=1 next cycle, no if_done; with IF_CTRL_STALL_EN, stall high 2 cycles mid-stream: if_done delayed exactly 2 cycles.
